// File: rtl/branch_resolver.sv
// Queues jXX predictions from fetch and resolves them at execute: trains the predictor and issues a redirect on a mispredict.
// Define BRES_STATS_EN to build the branch/mispredict performance counters; otherwise both outputs read 0.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             f_push_i,
  input  logic             f_taken_i,
  input  logic [63:0]      f_valC_i,
  input  logic [63:0]      f_valP_i,
  input  logic             e_pop_i,
  input  logic             e_Cnd_i,
  input  logic             squash_i,
  output logic             redirect_valid_o,
  output logic [63:0]      redirect_pc_o,
  output logic             train_valid_o,
  output logic             train_taken_o,
  output logic             train_mispredicted_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [DEPTH-1:0] taken_mem;
  logic [63:0]      valc_mem [DEPTH];
  logic [63:0]      valp_mem [DEPTH];

  logic        pop_ok;
  logic        head_taken;
  logic        mispredict;
  logic        push_live;
  logic        push_ok;
  logic        push_err;
  logic        pop_err;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head_taken = taken_mem[rd_ptr[AW-1:0]];
  assign pop_ok     = e_pop_i && !empty_o;
  assign mispredict = pop_ok && (head_taken != e_Cnd_i);

  assign train_valid_o        = pop_ok;
  assign train_taken_o        = e_Cnd_i;
  assign train_mispredicted_o = mispredict;

  // Pushes during a mispredict or the redirect cycle are wrong-path fetches: dropped silently.
  assign push_live = f_push_i && !squash_i && !mispredict && !redirect_valid_o;
  assign push_ok   = push_live && (!full_o || pop_ok);
  assign push_err  = push_live && full_o && !pop_ok;
  assign pop_err   = e_pop_i && empty_o && !squash_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      err_o            <= 1'b0;
    end else begin
      if (squash_i || mispredict) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      redirect_valid_o <= mispredict && !squash_i;
      if (mispredict && !squash_i)
        redirect_pc_o <= e_Cnd_i ? valc_mem[rd_ptr[AW-1:0]] : valp_mem[rd_ptr[AW-1:0]];
      if (push_err || pop_err) err_o <= 1'b1;
    end
  end

  // Entry storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      taken_mem[wr_ptr[AW-1:0]] <= f_taken_i;
      valc_mem[wr_ptr[AW-1:0]]  <= f_valC_i;
      valp_mem[wr_ptr[AW-1:0]]  <= f_valP_i;
    end
  end

`ifdef BRES_STATS_EN
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (!squash_i) begin
      if (pop_ok)     branch_cnt  <= branch_cnt + 1'b1;
      if (mispredict) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign branch_cnt_o  = branch_cnt;
  assign mispred_cnt_o = mispred_cnt;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Tracks every conditional jump (jXX) from fetch to execute in the Y86 pipeline. On a fetch-time prediction it queues the predicted direction and both candidate PCs. At execute it checks the real condition against the queued prediction, drives the training signals back to the gshare predictor, and on a mispredict issues a registered redirect PC with a flush of all younger queued branches. Optional performance counters report branch and mispredict totals.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2; at least the number of jXX that fit between fetch and execute.
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- f_push_i  in  1  a jXX leaves fetch this cycle (already qualified by stall/bubble).
- f_taken_i  in  1  direction predicted by the predictor for that jXX.
- f_valC_i  in  64  jump target.
- f_valP_i  in  64  fall-through PC.
- e_pop_i  in  1  a valid jXX is in execute this cycle.
- e_Cnd_i  in  1  actual condition outcome for that jXX.
- squash_i  in  1  external flush (ret/exception); clears the queue.
- redirect_valid_o  out  1  one-cycle pulse: fetch must restart at redirect_pc_o.
- redirect_pc_o  out  64  corrected PC.
- train_valid_o  out  1  equals e_pop_i && !empty_o.
- train_taken_o  out  1  actual direction (e_Cnd_i).
- train_mispredicted_o  out  1  head prediction differs from e_Cnd_i.
- full_o  out  1  queue holds DEPTH entries.
- empty_o  out  1  queue holds 0 entries.
- err_o  out  1  sticky: set by a push while full or a pop while empty.
- branch_cnt_o  out  CNT_W  resolved-branch count.
- mispred_cnt_o  out  CNT_W  mispredict count.

## Operation
- Storage: DEPTH entries of {taken, valC, valP}. Read and write pointers are log2(DEPTH)+1 bits wide.
  - empty: pointers are equal.
  - full: the MSBs differ and the remaining bits are equal.
  - Pointers wrap modulo 2·DEPTH.
- Push: when f_push_i && !full_o, the entry is written at the write pointer, then the write pointer increments.
- Push while full: the push is dropped and err_o is set.
- Pop: when e_pop_i && !empty_o:
  - The head entry is compared with e_Cnd_i combinationally. train_* outputs are valid in the same cycle.
  - The read pointer increments.
- Pop while empty: train_valid_o = 0 and err_o is set.
- Mispredict (pop && head.taken != e_Cnd_i):
  - Next cycle, redirect_valid_o = 1.
  - redirect_pc_o = valC if e_Cnd_i = 1, else valP.
  - At the same edge, both pointers reset to 0; the queue empties. All remaining entries are younger wrong-path branches.
  - A push in the mispredict cycle is discarded. It is wrong-path and does not set err_o.
  - A push in the redirect_valid_o cycle is also discarded (wrong-path fetch still in flight).
- squash_i: at the next edge, both pointers go to 0.
  - squash_i overrides pop and push in that cycle.
  - squash_i does not generate a redirect and does not clear a redirect already pending.
- Push and pop in the same cycle without a mispredict: both take effect. Occupancy stays the same. Allowed when full, because the pop frees the slot at the same edge.
- Counters, when compiled in (see Configuration):
  - branch_cnt_o increments on every valid pop.
  - mispred_cnt_o increments on every mispredict.
  - Both wrap modulo 2^CNT_W.

## Timing
Reset values (async assert):
- pointers 0, so empty_o = 1 and full_o = 0.
- redirect_valid_o = 0.
- redirect_pc_o = 0.
- err_o = 0.
- counters 0.

Latencies:
- train_* outputs: 0 cycles from e_pop_i (combinational on head entry and e_Cnd_i).
- redirect_valid_o / redirect_pc_o: registered, 1 cycle after the mispredicting pop. redirect_valid_o is high for exactly one cycle per mispredict.
- full_o / empty_o: combinational from registered pointers, so they reflect state after the last edge.
- Back-to-back mispredicts: impossible, because the queue is empty after the first. A pop in the redirect cycle is treated as a pop on empty.

Reset mid-operation: the queue, any pending redirect and err_o are all cleared immediately.

## Configuration
- BRES_STATS_EN defined: branch_cnt_o and mispred_cnt_o are live counters as described in Operation.
- BRES_STATS_EN undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Reset, then push {taken=1, valC=0x100, valP=0x10A}, then pop with e_Cnd_i=1 → train_valid_o=1, train_mispredicted_o=0; no redirect; empty_o=1.
- Push {taken=0, valC=0x200, valP=0x20A}, push {taken=1, …}, then pop with e_Cnd_i=1 → train_mispredicted_o=1 that cycle. Next cycle: redirect_valid_o=1, redirect_pc_o=0x200, empty_o=1 (second entry flushed).
- DEPTH=4: push 4 entries → full_o=1. Fifth push alone → err_o=1, queue unchanged. Fifth push together with a correct pop → accepted, full_o stays 1.
- Pop with e_Cnd_i=0 on a taken=1 entry while a push occurs → redirect_pc_o = that entry's valP; the push is discarded; err_o=0.
- squash_i with 3 entries queued and a simultaneous push → empty_o=1 next cycle; no redirect_valid_o.
- With BRES_STATS_EN: 10 pops, 3 of them mispredicting (each followed by a refill) → branch_cnt_o=10, mispred_cnt_o=3. Without BRES_STATS_EN: both read 0.
